// File: rtl/phase_pkg.sv
// Shared encodings and default constants for the five-phase sequencer.
package phase_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StRun    = 2'b01,
    StStep   = 2'b10,
    StHalted = 2'b11
  } seq_state_e;

  localparam int unsigned NUM_PHASES      = 5;
  localparam int unsigned PHASE_W         = 3;
  localparam int unsigned DEBOUNCE_CYCLES = 16;

  localparam int unsigned FETCH     = 0;
  localparam int unsigned DECODE    = 1;
  localparam int unsigned EXECUTE   = 2;
  localparam int unsigned MEMORY    = 3;
  localparam int unsigned WRITEBACK = 4;

  localparam int unsigned MEM_PHASE_A = FETCH;
  localparam int unsigned MEM_PHASE_B = MEMORY;

endpackage

// File: rtl/button_debouncer.sv
// Synchronizes an active-low pushbutton, filters bounce and emits a one-cycle press pulse.
module button_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic exec,
  output logic press
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]      sync_q, sync_d;
  logic            level_q, level_d;
  logic            press_q, press_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    sync_d  = {sync_q[0], exec};
    level_d = level_q;
    cnt_d   = '0;
    press_d = 1'b0;
    // Any sample matching the accepted level restarts the stability run.
    if (sync_q[1] != level_q) begin
      if (cnt_q == CntW'(DEBOUNCE_CYCLES - 1)) begin
        level_d = ~level_q;
        press_d = level_q;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q  <= 2'b11;
      level_q <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/phase_sequencer.sv
// Run/step/halt controller generating one-hot phase enables for the five-phase datapath.
module phase_sequencer #(
  parameter int unsigned NUM_PHASES      = phase_pkg::NUM_PHASES,
  parameter int unsigned DEBOUNCE_CYCLES = phase_pkg::DEBOUNCE_CYCLES,
  parameter int unsigned MEM_PHASE_A     = phase_pkg::MEM_PHASE_A,
  parameter int unsigned MEM_PHASE_B     = phase_pkg::MEM_PHASE_B
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  exec,
  input  logic                  step_mode,
  input  logic                  halt,
  input  logic                  mem_req,
  input  logic                  mem_ready,
  output logic [2:0]            phase,
  output logic [NUM_PHASES-1:0] p_en,
  output logic                  running,
  output logic [1:0]            state,
  output logic [15:0]           instr_count
);
  import phase_pkg::*;

  logic press;

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clock(clock),
    .reset(reset),
    .exec (exec),
    .press(press)
  );

  seq_state_e  state_q, state_d;
  logic [2:0]  phase_q, phase_d;
  logic        pause_q, pause_d;
  logic        running_q, running_d;
  logic [15:0] count_q, count_d;

  logic mem_phase, stall, advance, wrap;

  always_comb begin
    mem_phase = (phase_q == 3'(MEM_PHASE_A)) || (phase_q == 3'(MEM_PHASE_B));
    stall     = running_q & mem_req & ~mem_ready & mem_phase;
    advance   = running_q & ~stall;
    wrap      = advance & (phase_q == 3'(NUM_PHASES - 1));
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    pause_d = pause_q;
    count_d = count_q;

    if (advance) begin
      phase_d = wrap ? 3'd0 : phase_q + 3'd1;
      if (wrap) begin
        count_d = count_q + 16'd1;
      end
    end

    case (state_q)
      StIdle: begin
        if (press) begin
          state_d = step_mode ? StStep : StRun;
        end
      end
      StRun: begin
        pause_d = pause_q | press;
        // Halt outranks a pending pause; a press arriving on the wrap waits for the next one.
        if (wrap) begin
          if (halt) begin
            state_d = StHalted;
            pause_d = 1'b0;
          end else if (pause_q) begin
            state_d = StIdle;
            pause_d = 1'b0;
          end
        end
      end
      StStep: begin
        if (wrap) begin
          state_d = halt ? StHalted : StIdle;
        end
      end
      StHalted: begin
        if (press) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    running_d = (state_d == StRun) || (state_d == StStep);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      phase_q   <= 3'd0;
      pause_q   <= 1'b0;
      running_q <= 1'b0;
      count_q   <= 16'd0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      pause_q   <= pause_d;
      running_q <= running_d;
      count_q   <= count_d;
    end
  end

  assign phase       = phase_q;
  assign p_en        = advance ? (NUM_PHASES'(1) << phase_q) : '0;
  assign running     = running_q;
  assign state       = state_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// Self-checking bench for phase_sequencer: directed table, corner sequences, random vs model.
module tb_phase_sequencer;

  localparam int N = 16;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        exec = 1'b1;
  logic        step_mode = 1'b0;
  logic        halt = 1'b0;
  logic        mem_req = 1'b0;
  logic        mem_ready = 1'b1;
  logic [2:0]  phase;
  logic [4:0]  p_en;
  logic        running;
  logic [1:0]  state;
  logic [15:0] instr_count;

  int checks = 0;
  int failures = 0;
  int press_seen = 0;

  always #5 clock = ~clock;

  phase_sequencer dut (
    .clock      (clock),
    .reset      (reset),
    .exec       (exec),
    .step_mode  (step_mode),
    .halt       (halt),
    .mem_req    (mem_req),
    .mem_ready  (mem_ready),
    .phase      (phase),
    .p_en       (p_en),
    .running    (running),
    .state      (state),
    .instr_count(instr_count)
  );

  // Reference model: modes 0 idle, 1 run, 2 step, 3 halted.
  int m_state, m_phase, m_count;
  bit m_pend, m_press, m_level, m_s1, m_s2;
  bit win[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_phase = 0; m_count = 0;
    m_pend = 0; m_press = 0; m_level = 1; m_s1 = 1; m_s2 = 1;
    win.delete();
  endtask

  function automatic bit m_run();
    return (m_state == 1) || (m_state == 2);
  endfunction

  function automatic bit m_adv();
    bit st;
    st = m_run() && mem_req && !mem_ready && (m_phase == 0 || m_phase == 3);
    return m_run() && !st;
  endfunction

  function automatic logic [4:0] m_pen();
    if (m_adv()) return 5'(1) << m_phase;
    return 5'd0;
  endfunction

  task automatic model_update();
    bit adv, wr, all_diff;
    adv = m_adv();
    wr  = adv && (m_phase == 4);
    case (m_state)
      0: if (m_press) m_state = step_mode ? 2 : 1;
      1: begin
        if (wr && halt) begin m_state = 3; m_pend = 0; end
        else if (wr && m_pend) begin m_state = 0; m_pend = 0; end
        else if (m_press) m_pend = 1;
      end
      2: if (wr) m_state = halt ? 3 : 0;
      default: if (m_press) m_state = 0;
    endcase
    if (adv) begin
      if (wr) begin m_phase = 0; m_count = (m_count + 1) % 65536; end
      else m_phase = m_phase + 1;
    end
    // Accept a new level once the last N synchronized samples all disagree with it.
    win.push_back(m_s2);
    if (win.size() > N) void'(win.pop_front());
    all_diff = (win.size() == N);
    foreach (win[i]) if (win[i] == m_level) all_diff = 0;
    m_press = all_diff && m_level;
    if (all_diff) begin m_level = !m_level; win.delete(); end
    m_s2 = m_s1;
    m_s1 = exec;
  endtask

  // Entered just after a negedge with inputs applied; leaves at the following negedge.
  task automatic cyc();
    #1;
    check("m_state", state, m_state);
    check("m_phase", phase, m_phase);
    check("m_p_en", p_en, m_pen());
    check("m_running", running, m_run());
    check("m_instr_count", instr_count, m_count);
    if (dut.press) press_seen++;
    @(posedge clock);
    if (!reset) model_reset();
    else model_update();
    @(negedge clock);
  endtask

  task automatic wait_state(input int target, input int bound, input string name);
    for (int i = 0; i < bound; i++) begin
      if (state == 2'(target)) break;
      cyc();
    end
    check(name, state, target);
  endtask

  typedef struct {
    logic mreq;
    logic mrdy;
    logic hlt;
    int   ph;
    int   pen;
    int   st;
    int   cnt;
  } vec_t;

  vec_t tbl[15];

  initial begin
    int n, hold;
    tbl[0]  = '{1'b0, 1'b1, 1'b0, 0, 'h01, 1, 0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 1, 'h02, 1, 0};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 2, 'h04, 1, 0};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 3, 'h00, 1, 0};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 3, 'h00, 1, 0};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 3, 'h00, 1, 0};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 3, 'h08, 1, 0};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 4, 'h10, 1, 0};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 0, 'h00, 1, 1};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 0, 'h01, 1, 1};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 1, 'h02, 1, 1};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 2, 'h04, 1, 1};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 3, 'h08, 1, 1};
    tbl[13] = '{1'b0, 1'b1, 1'b1, 4, 'h10, 1, 1};
    tbl[14] = '{1'b0, 1'b1, 1'b0, 0, 'h00, 3, 2};

    model_reset();
    @(negedge clock);
    check("rst_state", state, 0);
    check("rst_phase", phase, 0);
    check("rst_p_en", p_en, 0);
    check("rst_count", instr_count, 0);
    cyc();
    reset = 1'b1;
    repeat (3) cyc();

    // Run mode: stall, ignored halt/mem_req, then halt at a wrap.
    exec = 1'b0;
    wait_state(1, 40, "enter_run");
    foreach (tbl[i]) begin
      mem_req = tbl[i].mreq; mem_ready = tbl[i].mrdy; halt = tbl[i].hlt;
      #1;
      check($sformatf("tbl%0d_phase", i), phase, tbl[i].ph);
      check($sformatf("tbl%0d_p_en", i), p_en, tbl[i].pen);
      check($sformatf("tbl%0d_state", i), state, tbl[i].st);
      check($sformatf("tbl%0d_count", i), instr_count, tbl[i].cnt);
      cyc();
    end
    mem_req = 1'b0; mem_ready = 1'b1; halt = 1'b0;
    exec = 1'b1;
    repeat (20) cyc();
    check("halted_holds", state, 3);
    exec = 1'b0;
    wait_state(0, 40, "halted_press_idle");
    check("halted_exit_phase", phase, 0);

    // Step mode with a second press while stalled at fetch.
    exec = 1'b1;
    repeat (20) cyc();
    step_mode = 1'b1; mem_req = 1'b1; mem_ready = 1'b0;
    exec = 1'b0; repeat (20) cyc();
    exec = 1'b1; repeat (20) cyc();
    exec = 1'b0; repeat (20) cyc();
    exec = 1'b1; repeat (20) cyc();
    check("step_stalled_state", state, 2);
    check("step_stalled_phase", phase, 0);
    mem_ready = 1'b1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (p_en != 5'd0) n++;
      cyc();
    end
    check("step_pulses", n, 5);
    check("step_end_state", state, 0);
    check("step_end_phase", phase, 0);
    check("step_end_count", instr_count, 3);
    step_mode = 1'b0; mem_req = 1'b0;

    // Pause pending plus halt at the wrap must halt.
    exec = 1'b0;
    wait_state(1, 40, "run_again");
    exec = 1'b1; repeat (20) cyc();
    exec = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (m_pend) break;
      cyc();
    end
    check("pause_pending_seen", m_pend, 1);
    halt = 1'b1;
    repeat (8) cyc();
    check("halt_beats_pause", state, 3);
    check("halt_phase_zero", phase, 0);
    halt = 1'b0;
    exec = 1'b1; repeat (20) cyc();
    exec = 1'b0;
    wait_state(0, 40, "halt_to_idle");

    // Bouncing button yields exactly one accepted press.
    exec = 1'b1; repeat (20) cyc();
    press_seen = 0;
    for (int i = 0; i < 10; i++) begin
      exec = ~exec;
      repeat (3) cyc();
    end
    exec = 1'b0;
    repeat (40) cyc();
    check("bounce_presses", press_seen, 1);
    check("bounce_state", state, 1);

    // Asynchronous reset in the middle of an instruction.
    for (int i = 0; i < 10; i++) begin
      if (phase == 3'd2) break;
      cyc();
    end
    check("pre_reset_phase", phase, 2);
    reset = 1'b0;
    #1;
    check("arst_state", state, 0);
    check("arst_phase", phase, 0);
    check("arst_p_en", p_en, 0);
    check("arst_running", running, 0);
    check("arst_count", instr_count, 0);
    model_reset();
    cyc();
    reset = 1'b1;
    exec = 1'b1;
    cyc();

    // Random stimulus against the model.
    hold = 0;
    for (int i = 0; i < 3000; i++) begin
      if (hold == 0) begin
        exec = 1'($urandom_range(0, 1));
        hold = $urandom_range(1, 40);
      end
      hold--;
      step_mode = 1'($urandom_range(0, 1));
      halt      = ($urandom_range(0, 7) == 0);
      mem_req   = 1'($urandom_range(0, 1));
      mem_ready = ($urandom_range(0, 3) != 0);
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/phase_sequencer.md
# phase_sequencer

Run/step/halt controller and phase generator for the five-phase processor datapath. It debounces the raw exec pushbutton and sequences phases 0..4 (fetch, decode, execute, memory, writeback). It stalls on memory handshakes and stops on a decoded halt. Outputs are one-hot phase enables and status that drive the datapath registers and the front-panel LEDs.

## Interface
- NUM_PHASES, 5, phases per instruction; phase counter width is 3 bits.
- DEBOUNCE_CYCLES, 16, consecutive stable synchronized samples required to accept a new exec level.
- MEM_PHASE_A, 0, phase index that may stall on memory (fetch).
- MEM_PHASE_B, 3, phase index that may stall on memory (data access).
- clock  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low; clears all state.
- exec  in  1  raw pushbutton, active-low, asynchronous to clock.
- step_mode  in  1  1 = single-instruction mode; sampled only when leaving IDLE.
- halt  in  1  decoded halt instruction; sampled only while p_en[4] is high.
- mem_req  in  1  current phase needs memory; meaningful only in MEM_PHASE_A/B.
- mem_ready  in  1  memory access complete this cycle.
- phase  out  3  current phase index, 0..NUM_PHASES-1.
- p_en  out  5  one-hot phase enable for the datapath; all zero when not advancing.
- running  out  1  high in RUN or STEP.
- state  out  2  IDLE=00, RUN=01, STEP=10, HALTED=11.
- instr_count  out  16  completed instructions; wraps 0xFFFF->0x0000.

## Operation
- Reset (reset low, asynchronous): state IDLE, phase 0, p_en 0, running 0, instr_count 0, debouncer level 1 (released), pause_pending 0.
- Debounce: exec passes through a 2-flop synchronizer. A counter tracks samples that differ from the accepted level; after DEBOUNCE_CYCLES consecutive differing samples, the accepted level flips and the counter clears. press is a single-cycle pulse on an accepted 1->0 transition.
- stall = running & mem_req & !mem_ready & (phase==MEM_PHASE_A | phase==MEM_PHASE_B).
- advance = running & !stall.
- p_en = onehot(phase) & {5{advance}}. This is combinational from registered phase/state and the mem inputs.
- On advance, phase increments; NUM_PHASES-1 wraps to 0 and instr_count increments.
- IDLE: press -> STEP if step_mode else RUN; phase is already 0.
- RUN: press sets pause_pending. At a wrap (advance with phase==4):
  - halt -> HALTED.
  - else if pause_pending -> IDLE; clear pause_pending.
  - else stay in RUN.
- STEP: press ignored. At a wrap:
  - halt -> HALTED.
  - else -> IDLE.
- HALTED: phase held at 0, p_en 0. press -> IDLE.
- Priority at a wrap: halt > pause_pending > continue.
- Entering IDLE or HALTED always leaves phase at 0. No partial instruction is ever abandoned except by reset.
- halt is ignored outside p_en[4]. mem_req is ignored outside MEM_PHASE_A/B.

## Timing
- exec falling edge before clock edge t is accepted at t+2+DEBOUNCE_CYCLES (typ.). press is high for that one cycle; state changes at the next edge.
- First p_en[0] is in the first cycle state==RUN/STEP, with no idle bubble. The unstalled instruction rate is one per 5 cycles.
- Stall: phase and p_en hold (p_en zero) for every cycle mem_ready is low. p_en of the stalled phase fires in the cycle mem_ready rises.
- Reset asserted mid-instruction clears outputs immediately, asynchronously. Release takes effect at the next clock edge.

## Structure
- Package phase_pkg: state encodings (IDLE/RUN/STEP/HALTED), NUM_PHASES, phase index constants (FETCH=0 .. WRITEBACK=4), MEM_PHASE_A/B defaults.
- Sub-module button_debouncer (synchronizer, stability counter, press-pulse output), parameterized by DEBOUNCE_CYCLES. The FSM, phase counter, stall logic and instr_count stay in phase_sequencer.

## Test plan
- Reset, then exec pulse held >20 cycles, step_mode=0, mem_ready=1 -> RUN. p_en cycles 00001,00010,00100,01000,10000; instr_count +1 every 5 cycles.
- step_mode=1 plus one press -> exactly 5 p_en pulses, then state IDLE, phase 0, instr_count=1. A second press mid-step has no effect.
- RUN with mem_req=1 and mem_ready=0 for 3 cycles at phase 3 -> phase held at 3, p_en=0 for 3 cycles, p_en[3] fires on the 4th.
- halt=1 during p_en[4] with a pause press pending in the same instruction -> state HALTED (not IDLE). The next press -> IDLE.
- exec bouncing (toggle every 3 cycles for 30 cycles, then stable low) -> exactly one press pulse.
- reset low during phase 2 in RUN -> state, phase, p_en and instr_count are all zero before the next clock edge.
